// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//
// NUM_REGS x DATA_WIDTH flops with one byte-enabled software write port,
// one hardware update port and NUM_RD independent registered read ports.
// Each register is read-write, read-only (hardware loaded) or
// write-1-to-clear (hardware sticky-set), selected by RO_MASK / W1C_MASK.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   wr_en     software write request
//   wr_addr   software write address
//   wr_data   software write data
//   wr_be     software write byte enables
//   wr_err    one-cycle pulse after a rejected write (RO or out of range)
//   rd_en     per-port read request
//   rd_addr   packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid  per-port response valid, one cycle after rd_en
//   rd_err    per-port address error, qualified by rd_valid
//   hw_we     hardware update strobe
//   hw_addr   hardware update address
//   hw_data   hardware update data
module regfile_mp #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter int                  NUM_RD     = 2,
  parameter int                  ADDR_WIDTH = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  output logic                           wr_err,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic [NUM_RD-1:0]              rd_err,
  input  logic                           hw_we,
  input  logic [ADDR_WIDTH-1:0]          hw_addr,
  input  logic [DATA_WIDTH-1:0]          hw_data
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]        regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]        regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0]        be_mask;
  logic                         wr_reject;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;
  logic [NUM_RD-1:0]            rd_err_d;

  // Expand byte enables to a bit mask.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      be_mask[b*8 +: 8] = {8{wr_be[b]}};
    end
  end

  // A write is rejected unless its address matches an existing register
  // that is not read-only. Comparing against each index avoids indexing
  // the masks with an out-of-range address.
  always_comb begin
    wr_reject = 1'b0;
    if (wr_en) begin
      wr_reject = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_addr == ADDR_WIDTH'(r)) begin
          wr_reject = RO_MASK[r];
        end
      end
    end
  end

  // Next-state per register. RO_MASK takes priority over W1C_MASK.
  // For W1C the software clear is applied before the hardware set so that
  // a coincident set wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (RO_MASK[r]) begin
        if (hw_we && (hw_addr == ADDR_WIDTH'(r))) begin
          regs_d[r] = hw_data;
        end
      end else if (W1C_MASK[r]) begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(r))) begin
          regs_d[r] = regs_d[r] & ~(wr_data & be_mask);
        end
        if (hw_we && (hw_addr == ADDR_WIDTH'(r))) begin
          regs_d[r] = regs_d[r] | hw_data;
        end
      end else begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(r))) begin
          regs_d[r] = (regs_q[r] & ~be_mask) | (wr_data & be_mask);
        end
      end
    end
  end

  // Read muxes select from the next-state array so a read sampled with a
  // write/update to the same address returns the post-update value.
  always_comb begin
    rd_data_d = '0;
    rd_err_d  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_err_d[i] = rd_en[i];
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
          rd_err_d[i] = 1'b0;
          if (rd_en[i]) begin
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_d[r];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      wr_err   <= 1'b0;
      rd_valid <= '0;
      rd_err   <= '0;
      rd_data  <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      wr_err   <= wr_reject;
      rd_valid <= rd_en;
      rd_err   <= rd_err_d;
      rd_data  <= rd_data_d;
    end
  end

endmodule
